// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and domain limit.
package reset_seq_pkg;

  localparam int RESET_SEQ_MAX_DOMAINS = 8;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_LOCK_WAIT = 3'd1,
    ST_REL_DELAY = 3'd2,
    ST_STAGED    = 3'd3,
    ST_ACTIVE    = 3'd4
  } reset_seq_state_t;

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the clock wizard / software side and the reset sequencer.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 2
);
  // soft_req is a single-cycle pulse in the sequencer clock domain. It has no
  // ready: the sequencer accepts it in every state, so one high cycle is one
  // request. locked is asynchronous and level-sensitive.
  logic                   locked;
  logic                   soft_req;
  logic [NUM_DOMAINS-1:0] dom_clk;
  logic [NUM_DOMAINS-1:0] reset_o;
  logic                   active_o;

  modport master (
    input  locked,
    input  soft_req,
    input  dom_clk,
    output reset_o,
    output active_o
  );

  modport slave (
    output locked,
    output soft_req,
    output dom_clk,
    input  reset_o,
    input  active_o
  );

endinterface

// File: rtl/reset_cdc_sync.sv
// Reset synchroniser into one destination clock. Flops power up asserted, so
// the destination domain is held in reset before the sequencer has run.
module reset_cdc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic oclk,
  input  logic isig,
  output logic osig
);

  logic [SYNC_STAGES-1:0] sync_q = '1;

  always_ff @(posedge oclk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], isig};
  end

  assign osig = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release after MMCM lock, with software re-reset.
// Define RESET_SEQ_LOCKLOSS_EN to restart the sequence on loss of lock.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int DELAY_W     = 10,
  parameter int REL_DELAY   = 1023,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  reset_sequencer_if.master      bus,
  output reset_seq_state_t       state_o,
  output logic [NUM_DOMAINS-1:0] ireset_o
);

  localparam int IDX_W = $clog2(RESET_SEQ_MAX_DOMAINS + 1);

  reset_seq_state_t       state_q, state_d;
  logic [DELAY_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] ireset_q, ireset_d;
  logic                   active_q, active_d;
  logic                   lock_s1_q, lock_s2_q;
  logic                   lock_lost;
  logic                   restart;

  // Plain two-flop synchroniser; not reset so a held lock survives a re-reset.
  always_ff @(posedge clk) begin
    lock_s1_q <= bus.locked;
    lock_s2_q <= lock_s1_q;
  end

`ifdef RESET_SEQ_LOCKLOSS_EN
  assign lock_lost = !lock_s2_q &&
                     ((state_q == ST_REL_DELAY) || (state_q == ST_STAGED) ||
                      (state_q == ST_ACTIVE));
`else
  assign lock_lost = 1'b0;
`endif

  assign restart = bus.soft_req || lock_lost;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ireset_d = ireset_q;
    if (restart) begin
      state_d  = ST_INIT;
      cnt_d    = DELAY_W'(REL_DELAY);
      idx_d    = '0;
      ireset_d = '1;
    end else begin
      case (state_q)
        ST_INIT:      state_d = ST_LOCK_WAIT;
        ST_LOCK_WAIT: if (lock_s2_q) state_d = ST_REL_DELAY;
        ST_REL_DELAY: begin
          if (cnt_q == '0) begin
            ireset_d[0] = 1'b0;
            idx_d       = IDX_W'(1);
            cnt_d       = DELAY_W'(STAGE_GAP - 1);
            state_d     = (NUM_DOMAINS == 1) ? ST_ACTIVE : ST_STAGED;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        ST_STAGED: begin
          if (cnt_q == '0) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (idx_q == IDX_W'(k)) ireset_d[k] = 1'b0;
            end
            idx_d = idx_q + IDX_W'(1);
            cnt_d = DELAY_W'(STAGE_GAP - 1);
            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) state_d = ST_ACTIVE;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        ST_ACTIVE: state_d = ST_ACTIVE;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  // Registered one cycle behind the ACTIVE entry, but dropped on the exit edge.
  assign active_d = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= DELAY_W'(REL_DELAY);
      idx_q    <= '0;
      ireset_q <= '1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ireset_q <= ireset_d;
      active_q <= active_d;
    end
  end

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_sync
    reset_cdc_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .oclk(bus.dom_clk[k]),
      .isig(ireset_q[k]),
      .osig(bus.reset_o[k])
    );
  end

  assign bus.active_o = active_q;
  assign state_o      = state_q;
  assign ireset_o     = ireset_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model of release times, table vectors,
// random restarts, per-domain synchroniser scoreboards and a one-domain instance.
`timescale 1ns/1ps
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int ND  = 2;
  localparam int RD  = 1023;
  localparam int GAP = 16;
  localparam int SS  = 2;
  localparam longint INF = 64'sh3fff_ffff_ffff_ffff;
  localparam logic [ND-1:0] ALL1 = '1;

  logic clk = 1'b0, reset = 1'b1, dom0 = 1'b0, dom1 = 1'b0;
  logic chk_en = 1'b0;
  longint cyc = 0;
  longint m_a = 0, m_r = INF;
  int pass_cnt = 0, total_cnt = 0;

  reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();
  reset_sequencer_if #(.NUM_DOMAINS(1))  bus1 ();
  reset_seq_state_t st, st1;
  logic [ND-1:0] ire;
  logic [0:0]    ire1;

  reset_sequencer #(
    .NUM_DOMAINS(ND), .DELAY_W(10), .REL_DELAY(RD), .STAGE_GAP(GAP), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .state_o(st), .ireset_o(ire)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .DELAY_W(10), .REL_DELAY(3), .STAGE_GAP(GAP), .SYNC_STAGES(SS)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master), .state_o(st1), .ireset_o(ire1)
  );

  // Clock and reset generation: clk 100 MHz, dom0 100 MHz, dom1 200 MHz, all offset.
  always #5 clk = ~clk;
  initial begin #2;   forever #5   dom0 = ~dom0; end
  initial begin #1;   forever #2.5 dom1 = ~dom1; end
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.dom_clk   = {dom1, dom0};
  assign bus1.dom_clk  = dom0;
  assign bus1.locked   = bus.locked;
  assign bus1.soft_req = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference timeline: sequence entry is the later of two cycles after the last
  // restart and three cycles after lock rose; domain k clears k gaps after domain 0.
  function automatic longint clr_at(input int k);
    longint e;
    if (m_r == INF) return INF;
    e = (m_a + 2 > m_r + 3) ? m_a + 2 : m_r + 3;
    return e + RD + 1 + longint'(k) * GAP;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < ND; k++)
        check($sformatf("ireset[%0d]@%0d", k, cyc), longint'(ire[k]), (cyc < clr_at(k)) ? 1 : 0);
      check($sformatf("active@%0d", cyc), longint'(bus.active_o), (cyc >= clr_at(ND-1) + 1) ? 1 : 0);
    end
  end

  // Scoreboard per domain: reset_o equals ireset as sampled SS own edges earlier.
  for (genvar g = 0; g < ND; g++) begin : g_mon
    logic [0:0] exp_q[$];
    initial begin
      logic [0:0] e;
      wait (chk_en);
      for (int i = 0; i < SS - 1; i++) exp_q.push_back(1'b1);
      forever begin
        @(posedge bus.dom_clk[g]);
        exp_q.push_back(ire[g]);
        e = exp_q.pop_front();
        #1;
        check($sformatf("reset_o[%0d]", g), longint'(bus.reset_o[g]), longint'(e));
      end
    end
  end

  // Single-domain instance: release 4 cycles after REL_DELAY entry, active 1 later.
  longint t_rel1 = 0, t_fall1 = 0;
  reset_seq_state_t prev_st1;
  logic prev_ire1 = 1'b1, prev_act1 = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (st1 == ST_REL_DELAY && prev_st1 != ST_REL_DELAY) t_rel1 = cyc;
      if (prev_ire1 && !ire1[0]) begin
        check("nd1_release", cyc - t_rel1, 4);
        t_fall1 = cyc;
      end
      if (!prev_act1 && bus1.active_o) check("nd1_active", cyc - t_fall1, 1);
    end
    prev_st1  = st1;
    prev_ire1 = ire1[0];
    prev_act1 = bus1.active_o;
  end

  // Driver: reset with lock low, raise lock after L cycles, optional soft_req at S.
  task automatic run_seq(input int l, input int s, input logic [ND-1:0] pre,
                         output int c0, output int c1, output int ca);
    int t;
    logic [ND-1:0] pi;
    logic pa;
    c0 = -1; c1 = -1; ca = -1;
    @(negedge clk); reset = 1'b1; bus.locked = 1'b0; bus.soft_req = 1'b0;
    @(posedge clk); #1; m_a = cyc; m_r = INF;
    @(negedge clk); reset = 1'b0;
    pi = ire; pa = bus.active_o; t = 0;
    while (t < 2300 && ca < 0) begin
      if (t == l) begin m_r = cyc; bus.locked = 1'b1; end
      bus.soft_req = (s > 0 && t == s - 1);
      if (s > 0 && t == s - 1) check("pre_soft_ireset", longint'(ire), longint'(pre));
      if (s > 0 && t == s) begin
        check("post_soft_ireset", longint'(ire), longint'(ALL1));
        check("post_soft_state", longint'(st), longint'(ST_INIT));
      end
      if (pi[0] && !ire[0]) c0 = t;
      if (pi[ND-1] && !ire[ND-1]) c1 = t;
      if (!pa && bus.active_o) ca = t;
      pi = ire; pa = bus.active_o;
      @(posedge clk); #1;
      if (s > 0 && t + 1 == s) m_a = cyc;
      @(negedge clk); t++;
    end
    bus.soft_req = 1'b0;
  endtask

  typedef struct {
    int lock_dly;
    int soft_at;
    logic [ND-1:0] pre;
    int exp_c0;
    int exp_c1;
    int exp_act;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, c1, ca, l, s, base, f0;
    longint t0;
    logic [ND-1:0] pre;

    vecs[0] = '{47,   0,    2'b11, 1074, 1090, 1091};
    vecs[1] = '{0,    0,    2'b11, 1027, 1043, 1044};
    vecs[2] = '{10,   500,  2'b11, 1526, 1542, 1543};
    vecs[3] = '{20,   1055, 2'b10, 2081, 2097, 2098};
    vecs[4] = '{5,    1,    2'b11, 1032, 1048, 1049};

    bus.locked = 1'b0; bus.soft_req = 1'b0;
    repeat (3) @(posedge clk);
    #1; m_a = cyc; m_r = INF;
    @(negedge clk); reset = 1'b0; chk_en = 1'b1;
    check("rst_ireset",  longint'(ire), longint'(ALL1));
    check("rst_active",  longint'(bus.active_o), 0);
    check("rst_reset_o", longint'(bus.reset_o), longint'(ALL1));
    check("rst_state",   longint'(st), longint'(ST_INIT));

    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i].lock_dly, vecs[i].soft_at, vecs[i].pre, c0, c1, ca);
      check($sformatf("vec%0d_clear0", i), c0, vecs[i].exp_c0);
      check($sformatf("vec%0d_clear1", i), c1, vecs[i].exp_c1);
      check($sformatf("vec%0d_active", i), ca, vecs[i].exp_act);
    end

    for (int r = 0; r < 3; r++) begin
      l = $urandom_range(0, 40);
      s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, l + 1040) : 0;
      f0 = l + 3 + RD + 1;
      pre = ALL1;
      for (int k = 0; k < ND; k++) if (s > 0 && s - 1 >= f0 + k * GAP) pre[k] = 1'b0;
      base = l + 3;
      if (s > 0 && s + 2 > base) base = s + 2;
      run_seq(l, s, pre, c0, c1, ca);
      check($sformatf("rand%0d_clear0", r), c0, base + RD + 1);
      check($sformatf("rand%0d_clear1", r), c1, base + RD + 1 + GAP);
      check($sformatf("rand%0d_active", r), ca, base + RD + 1 + GAP + 1);
    end

    // soft_req in ACTIVE: everything reasserts, then a full rerun with lock held.
    @(negedge clk); bus.soft_req = 1'b1;
    @(posedge clk); #1; m_a = cyc; t0 = cyc;
    @(negedge clk); bus.soft_req = 1'b0;
    check("soft_active_drop", longint'(bus.active_o), 0);
    check("soft_state_init", longint'(st), longint'(ST_INIT));
    repeat (3) @(negedge clk);
    check("soft_reset_o", longint'(bus.reset_o), longint'(ALL1));
    for (int i = 0; i < 1200 && !bus.active_o; i++) @(negedge clk);
    check("soft_rerun_active", cyc - t0, 2 + RD + 1 + GAP + 1);

    // Lock loss in ACTIVE for 5 cycles.
    @(negedge clk); t0 = cyc; bus.locked = 1'b0;
`ifdef RESET_SEQ_LOCKLOSS_EN
    repeat (3) @(posedge clk);
    #1; m_a = cyc; m_r = INF;
    repeat (3) @(negedge clk);
    bus.locked = 1'b1; m_r = cyc;
    check("lockloss_active", longint'(bus.active_o), 0);
    check("lockloss_reset_o", longint'(bus.reset_o), longint'(ALL1));
    for (int i = 0; i < 1200 && !bus.active_o; i++) @(negedge clk);
    check("lockloss_restart", cyc - t0, 8 + RD + 1 + GAP + 1);
`else
    repeat (5) @(negedge clk);
    bus.locked = 1'b1;
    repeat (5) @(negedge clk);
    check("lockloss_ignored", longint'(bus.active_o), 1);
    check("lockloss_reset_o", longint'(bus.reset_o), 0);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
